mod_addsub_ctrl: RTL and testbench

//  Initiator for the mpadder start/subtract/done handshake. Computes (a+b) mod m or (a-b) mod m.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/mod_addsub_ctrl.sv | 106 ++++++++++
 tb/tb_mod_addsub_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants: operand widths, controller state encoding and add/sub modes.
package rsa_pkg;

  localparam int N  = 1024;
  localparam int AW = N + 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t WAIT1 = 2'd1;
  localparam state_t WAIT2 = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract initiator: drives the shared mpadder through a raw op and a correction op,
// then picks the final value from the sign of the intermediate results. Data-independent timing.
module mod_addsub_ctrl
  import rsa_pkg::*;
#(
  parameter int N  = rsa_pkg::N,
  parameter int AW = rsa_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          subtract,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          busy,
  output logic          add_start,
  output logic          add_subtract,
  output logic [AW-1:0] add_in_a,
  output logic [AW-1:0] add_in_b,
  input  logic [AW:0]   add_result,
  input  logic          add_done
);

  localparam int EXT = AW - N;

  state_t         state;
  logic           mode;
  logic [N-1:0]   m_q;
  logic [N-1:0]   r_low;
  logic           r_neg;
  logic           add_taken;
  logic [N-1:0]   sel;

  // A done seen while our own start is still high belongs to the previous operation.
  assign add_taken = add_done && !add_start;

  // Final pick: add mode keeps r when r-m went negative; sub mode takes r+m when r went negative.
  always_comb begin
    sel = r_low;
    if (mode == MODE_ADD) begin
      if (!add_result[AW]) sel = add_result[N-1:0];
    end else if (r_neg) begin
      sel = add_result[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mode         <= MODE_ADD;
      m_q          <= '0;
      r_low        <= '0;
      r_neg        <= 1'b0;
      result       <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      // NOTE: non-blocking defaults make done/add_start single-cycle pulses unless a branch re-asserts them.
      done      <= 1'b0;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          // done still high means this is the completion cycle; a start here is not taken.
          if (start && !done) begin
            mode         <= subtract;
            m_q          <= in_m;
            add_in_a     <= {{EXT{1'b0}}, in_a};
            add_in_b     <= {{EXT{1'b0}}, in_b};
            add_subtract <= subtract;
            add_start    <= 1'b1;
            busy         <= 1'b1;
            state        <= WAIT1;
          end
        end
        WAIT1: begin
          if (add_taken) begin
            r_low        <= add_result[N-1:0];
            r_neg        <= add_result[AW];
            add_in_a     <= add_result[AW-1:0];
            add_in_b     <= {{EXT{1'b0}}, m_q};
            add_subtract <= (mode == MODE_ADD);
            add_start    <= 1'b1;
            state        <= WAIT2;
          end
        end
        WAIT2: begin
          if (add_taken) begin
            result <= sel;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Self-checking bench for mod_addsub_ctrl around a behavioural mpadder with start->done latency L.
module tb_mod_addsub_ctrl;
  import rsa_pkg::*;

  localparam int L       = 3;
  localparam int LAT_EXP = 2 * (L + 1) + 1;
  localparam int TMO     = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          subtract;
  logic [N-1:0]  in_a, in_b, in_m;
  logic [N-1:0]  result;
  logic          done, busy;
  logic          add_start, add_subtract;
  logic [AW-1:0] add_in_a, add_in_b;
  logic [AW:0]   add_result;
  logic          add_done;

  int n_cmp = 0;
  int n_bad = 0;
  int n_add_start = 0;
  logic [N-1:0] exp_q[$];

  mod_addsub_ctrl #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done), .busy(busy),
    .add_start(add_start), .add_subtract(add_subtract), .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural mpadder: done rises L cycles after add_start rises; hold_done keeps it high as a level.
  bit            hold_done = 1'b0;
  bit            add_pend;
  int            add_cnt;
  logic [AW-1:0] op_a, op_b;
  logic          op_sub;

  always @(posedge clk) begin
    if (reset) begin
      add_done   <= 1'b0;
      add_pend   <= 1'b0;
      add_cnt    <= 0;
      add_result <= '0;
    end else if (add_start) begin
      op_a     <= add_in_a;
      op_b     <= add_in_b;
      op_sub   <= add_subtract;
      add_pend <= 1'b1;
      add_cnt  <= L - 1;
      add_done <= 1'b0;
    end else if (add_pend) begin
      if (add_cnt == 1) begin
        add_done   <= 1'b1;
        add_pend   <= 1'b0;
        add_result <= op_sub ? ({1'b0, op_a} - {1'b0, op_b}) : ({1'b0, op_a} + {1'b0, op_b});
      end
      add_cnt <= add_cnt - 1;
    end else if (!hold_done) begin
      add_done <= 1'b0;
    end
  end

  always @(negedge clk) if (add_start === 1'b1) n_add_start++;

  function automatic logic [N-1:0] model(input logic [N-1:0] a, b, m, input logic sub);
    logic [N:0] t;
    if (!sub) begin
      t = {1'b0, a} + {1'b0, b};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end else if (a >= b) begin
      t = {1'b0, a} - {1'b0, b};
    end else begin
      t = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One request: push the expectation, drive start, wait for done, then check result/latency/pulses.
  // poke re-strobes start with other operands while busy.
  task automatic run_op(input logic [N-1:0] a, b, m, input logic sub, input logic [N-1:0] exp,
                        input bit chk, input bit poke, input string name);
    int cyc;
    int p0;
    logic [N-1:0] want;
    exp_q.push_back(exp);
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
    p0 = n_add_start;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (poke && cyc == 3) begin
        start = 1'b1; in_a = 'd1; in_b = 'd2; in_m = 'd7; subtract = ~sub;
      end
      if (poke && cyc == 4) start = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
    end while (done !== 1'b1 && cyc < TMO);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
      void'(exp_q.pop_front());
      return;
    end
    want = exp_q.pop_front();
    if (chk) begin
      n_cmp++;
      if (result !== want) begin
        n_bad++;
        $display("FAIL %s result: got[255:0]=%h exp[255:0]=%h", name, result[255:0], want[255:0]);
      end
    end
    // Latency counts cycle 1 as the one right after the edge that sampled start.
    n_cmp++;
    if (cyc + 1 != LAT_EXP) begin
      n_bad++;
      $display("FAIL %s latency: got %0d exp %0d", name, cyc + 1, LAT_EXP);
    end
    n_cmp++;
    if (n_add_start - p0 != 2) begin
      n_bad++;
      $display("FAIL %s add_start pulses: got %0d exp 2", name, n_add_start - p0);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy in done cycle: got %b exp 1", name, busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after done: done=%b busy=%b exp 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0; in_m = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut.state !== IDLE || result !== '0 || done !== 1'b0 || busy !== 1'b0 ||
        add_start !== 1'b0 || add_subtract !== 1'b0 || add_in_a !== '0 || add_in_b !== '0) begin
      n_bad++;
      $display("FAIL reset: state=%0d done=%b busy=%b add_start=%b add_sub=%b exp all 0",
               dut.state, done, busy, add_start, add_subtract);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    run_op(N'(5), N'(9), N'(11), MODE_ADD, N'(3), 1'b1, 1'b0, "add_wrap");
    run_op(N'(4), N'(5), N'(11), MODE_ADD, N'(9), 1'b1, 1'b0, "add_nowrap");
  endtask

  task automatic test_sub();
    run_op(N'(3), N'(7), N'(11), MODE_SUB, N'(7), 1'b1, 1'b0, "sub_neg");
    run_op(N'(7), N'(3), N'(11), MODE_SUB, N'(4), 1'b1, 1'b0, "sub_pos");
    run_op(N'(16'h1234), N'(16'h1234), N'(16'h2000), MODE_SUB, N'(0), 1'b1, 1'b0, "sub_equal");
  endtask

  task automatic test_top_bit();
    logic [N-1:0] mmax;
    logic [N-1:0] want;
    mmax = '1;
    want = mmax - 2;
    run_op(mmax - 1, mmax - 1, mmax, MODE_ADD, want, 1'b1, 1'b0, "top_add");
    run_op(N'(0), mmax - 1, mmax, MODE_SUB, N'(1), 1'b1, 1'b0, "top_sub");
  endtask

  task automatic test_busy_ignore();
    run_op(N'(5), N'(9), N'(11), MODE_ADD, N'(3), 1'b1, 1'b1, "busy_ignore");
  endtask

  task automatic test_hold_done();
    hold_done = 1'b1;
    run_op(N'(5), N'(9), N'(11), MODE_ADD, N'(3), 1'b1, 1'b0, "hold_add");
    run_op(N'(3), N'(7), N'(11), MODE_SUB, N'(7), 1'b1, 1'b0, "hold_sub");
    hold_done = 1'b0;
  endtask

  // start held high through done: the done cycle must not accept, the next IDLE cycle must.
  task automatic test_back_to_back();
    int cyc;
    logic [N-1:0] want;
    exp_q.push_back(N'(3));
    exp_q.push_back(N'(9));
    @(negedge clk);
    in_a = N'(5); in_b = N'(9); in_m = N'(11); subtract = MODE_ADD; start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      do begin
        @(posedge clk);
        cyc++;
        #1;
      end while (done !== 1'b1 && cyc < TMO);
      want = exp_q.pop_front();
      n_cmp++;
      if (done !== 1'b1 || result !== want) begin
        n_bad++;
        $display("FAIL b2b op%0d: done=%b got[63:0]=%h exp[63:0]=%h", k, done, result[63:0], want[63:0]);
      end
      if (k == 0) begin
        @(negedge clk);
        in_a = N'(4); in_b = N'(5);
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b start in done cycle: busy got %b exp 0", busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b start after done: busy got %b exp 1", busy);
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    in_a = N'(5); in_b = N'(9); in_m = N'(11); subtract = MODE_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
    end while (dut.state !== WAIT2 && cyc < TMO);
    n_cmp++;
    if (dut.state !== WAIT2) begin
      n_bad++;
      $display("FAIL reset_mid: never reached WAIT2, state=%0d", dut.state);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dut.state !== IDLE || add_start !== 1'b0 || done !== 1'b0 || result !== '0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: state=%0d add_start=%b done=%b busy=%b result[63:0]=%h exp 0",
               dut.state, add_start, done, busy, result[63:0]);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(N'(5), N'(9), N'(11), MODE_ADD, N'(3), 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_out_of_range();
    run_op(N'(20), N'(30), N'(11), MODE_ADD, '0, 1'b0, 1'b0, "oor_add");
    run_op(N'(3), N'(40), N'(11), MODE_SUB, '0, 1'b0, 1'b0, "oor_sub");
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, m;
    logic sub;
    void'($urandom(32'd20240611));
    for (int i = 0; i < 1000; i++) begin
      m = rand_wide() >> $urandom_range(0, N - 2);
      if (m == '0) m = N'(1);
      a = rand_wide() % m;
      b = rand_wide() % m;
      if (i % 8 == 0) a = m - 1;
      if (i % 8 == 1) b = m - 1;
      sub = 1'($urandom_range(0, 1));
      run_op(a, b, m, sub, model(a, b, m, sub), 1'b1, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_top_bit();
    test_busy_ignore();
    test_hold_done();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
